// File: rtl/fifo_rd_stream_if.sv
// Bundles the FIFO read-side and downstream stream signals of fifo_rd_stream.
// master is the block's view; slave is the view of the FIFO plus consumer around it.
interface fifo_rd_stream_if #(
  parameter int DSIZE = 8
);
  // FIFO side: a word is popped at a rising edge whenever rinc=1 (rinc only rises while rempty=0).
  // Stream side: a word moves at a rising edge when out_valid && out_ready; out_data is held
  // stable while out_valid=1 and out_ready=0.
  logic             rempty;
  logic [DSIZE-1:0] rdata;
  logic             rinc;
  logic             out_valid;
  logic             out_ready;
  logic [DSIZE-1:0] out_data;

  modport master (
    input  rempty,
    input  rdata,
    output rinc,
    output out_valid,
    input  out_ready,
    output out_data
  );

  modport slave (
    output rempty,
    output rdata,
    input  rinc,
    input  out_valid,
    output out_ready,
    input  out_data
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// Turns a FIFO read port into a valid/ready stream through a 2-entry skid buffer,
// so FIFO pops never wait on the consumer's ready in the same cycle.
module fifo_rd_stream #(
  parameter int DSIZE = 8,
  parameter int CSIZE = 16
) (
  input  logic             rclk,
  input  logic             rrst_n,
  fifo_rd_stream_if.master bus,
  input  logic             flush,
  output logic [1:0]       buf_level,
  output logic [CSIZE-1:0] word_cnt
);

  logic [1:0]       count_q, count_d;
  logic             wr_idx_q;
  logic             rd_idx_q;
  logic [CSIZE-1:0] word_cnt_q;
  logic [DSIZE-1:0] mem_q [2];

  logic push;
  logic xfer;

  // rinc is gated by rrst_n so the FIFO is never popped while the buffer is held in reset.
  assign push = rrst_n && !bus.rempty && (count_q < 2'd2) && !flush;
  assign xfer = bus.out_valid && bus.out_ready && !flush;

  assign bus.rinc      = push;
  assign bus.out_valid = (count_q != 2'd0);
  assign bus.out_data  = mem_q[rd_idx_q];
  assign buf_level     = count_q;
  assign word_cnt      = word_cnt_q;

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case ({push, xfer})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      count_q    <= 2'd0;
      wr_idx_q   <= 1'b0;
      rd_idx_q   <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      count_q <= count_d;
      if (flush) begin
        wr_idx_q <= 1'b0;
        rd_idx_q <= 1'b0;
      end else begin
        if (push) wr_idx_q <= ~wr_idx_q;
        if (xfer) begin
          rd_idx_q   <= ~rd_idx_q;
          word_cnt_q <= word_cnt_q + {{(CSIZE-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  // Payload storage carries no reset; out_data is meaningless while out_valid=0.
  always_ff @(posedge rclk) begin
    if (push) mem_q[wr_idx_q] <= bus.rdata;
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream: a FIFO model feeds words, a scoreboard queue
// holds popped-but-undelivered words and checks the stream order and status outputs.
module tb_fifo_rd_stream;
  localparam int DSIZE = 8;
  localparam int CSIZE = 16;

  logic             rclk = 1'b0;
  logic             rrst_n = 1'b0;
  logic             flush = 1'b0;
  logic [1:0]       buf_level, w_buf_level;
  logic [CSIZE-1:0] word_cnt;
  logic [3:0]       w_word_cnt;

  fifo_rd_stream_if #(.DSIZE(DSIZE)) rif ();
  fifo_rd_stream_if #(.DSIZE(DSIZE)) wif ();

  assign wif.rempty    = rif.rempty;
  assign wif.rdata     = rif.rdata;
  assign wif.out_ready = rif.out_ready;

  always #5 rclk = ~rclk;

  fifo_rd_stream #(.DSIZE(DSIZE), .CSIZE(CSIZE)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .bus(rif), .flush(flush),
    .buf_level(buf_level), .word_cnt(word_cnt)
  );

  fifo_rd_stream #(.DSIZE(DSIZE), .CSIZE(4)) dut_w (
    .rclk(rclk), .rrst_n(rrst_n), .bus(wif), .flush(flush),
    .buf_level(w_buf_level), .word_cnt(w_word_cnt)
  );

  logic [DSIZE-1:0] src_q [$];
  logic [DSIZE-1:0] exp_q [$];
  logic [CSIZE-1:0] exp_cnt;
  logic             stall;
  int               xfers;
  int               errors;
  int               checks;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_src();
    rif.rempty = (src_q.size() == 0) || stall;
    rif.rdata  = (src_q.size() != 0) ? src_q[0] : '0;
  endtask

  // One clock cycle: check, sample the pre-edge handshake, update the model at the edge.
  task automatic tick();
    logic             s_rinc, s_xfer, exp_rinc;
    logic [DSIZE-1:0] s_data;
    #1;
    exp_rinc = (src_q.size() != 0) && !stall && (exp_q.size() < 2) && !flush;
    check("rinc", rif.rinc, exp_rinc);
    check("out_valid", rif.out_valid, exp_q.size() != 0);
    check("buf_level", buf_level, exp_q.size());
    check("word_cnt", word_cnt, exp_cnt);
    check("wrap_cnt", w_word_cnt, exp_cnt[3:0]);
    s_rinc = rif.rinc;
    s_xfer = rif.out_valid && rif.out_ready && !flush;
    s_data = rif.out_data;
    if (s_xfer && exp_q.size() != 0) check("out_data", s_data, exp_q[0]);
    @(posedge rclk);
    if (flush) begin
      exp_q.delete();
    end else begin
      if (s_xfer && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        exp_cnt++;
        xfers++;
      end
      if (s_rinc && src_q.size() != 0) exp_q.push_back(src_q.pop_front());
    end
    @(negedge rclk);
    drive_src();
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_cnt = '0;
  endtask

  initial begin
    logic [CSIZE-1:0] cnt0;
    int               x0;
    int               cyc;
    errors = 0;
    checks = 0;
    xfers  = 0;
    stall  = 1'b0;
    exp_cnt = '0;
    rif.out_ready = 1'b0;

    // Reset with a word offered: nothing may be popped or shown.
    src_q.push_back(8'h77);
    drive_src();
    #3;
    check("rst_rinc", rif.rinc, 0);
    check("rst_valid", rif.out_valid, 0);
    check("rst_level", buf_level, 0);
    check("rst_cnt", word_cnt, 0);
    src_q.delete();
    drive_src();
    @(negedge rclk);
    rrst_n = 1'b1;
    repeat (3) tick();

    // First word latency: popped in cycle N, visible in N+1.
    src_q.push_back(8'hA5);
    rif.out_ready = 1'b1;
    drive_src();
    tick();
    check("lat_valid", rif.out_valid, 1);
    check("lat_data", rif.out_data, 8'hA5);
    tick();
    check("lat_cnt", word_cnt, 1);

    // Backpressure: two pops fill the buffer, the third word waits in the FIFO.
    rif.out_ready = 1'b0;
    src_q.push_back(8'h01);
    src_q.push_back(8'h02);
    src_q.push_back(8'h03);
    drive_src();
    repeat (4) tick();
    #1;
    check("bp_level", buf_level, 2);
    check("bp_rinc", rif.rinc, 0);
    check("bp_pops", src_q.size(), 1);
    check("bp_hold", rif.out_data, 8'h01);
    rif.out_ready = 1'b1;
    x0 = xfers;
    repeat (3) tick();
    check("bp_consec", xfers - x0, 3);
    repeat (2) tick();

    // Throughput: 256 words at one word per cycle after a single fill cycle.
    cnt0 = exp_cnt;
    x0 = xfers;
    for (int i = 0; i < 256; i++) src_q.push_back(DSIZE'($urandom_range(0, 255)));
    drive_src();
    cyc = 0;
    while ((xfers - x0) < 256 && cyc < 400) begin
      tick();
      cyc++;
    end
    check("tp_words", xfers - x0, 256);
    check("tp_cycles", cyc, 257);
    check("tp_cnt", word_cnt, cnt0 + 16'd256);

    // Flush a full buffer: no pop that cycle, next FIFO word is delivered next.
    rif.out_ready = 1'b0;
    src_q.push_back(8'hB0);
    src_q.push_back(8'hB1);
    src_q.push_back(8'hB2);
    src_q.push_back(8'hB3);
    drive_src();
    repeat (3) tick();
    check("fl_pre_level", buf_level, 2);
    cnt0 = exp_cnt;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_level", buf_level, 0);
    check("fl_valid", rif.out_valid, 0);
    check("fl_cnt", word_cnt, cnt0);
    check("fl_src", src_q.size(), 2);
    rif.out_ready = 1'b1;
    tick();
    check("fl_next", rif.out_data, 8'hB2);
    repeat (3) tick();

    // Counter wrap on the CSIZE=4 instance after 17 words from reset.
    rrst_n = 1'b0;
    src_q.delete();
    model_reset();
    drive_src();
    @(negedge rclk);
    rrst_n = 1'b1;
    for (int i = 0; i < 17; i++) src_q.push_back(DSIZE'(8'hC0 + i));
    drive_src();
    x0 = xfers;
    cyc = 0;
    while ((xfers - x0) < 17 && cyc < 60) begin
      tick();
      cyc++;
    end
    check("wrap17", w_word_cnt, 1);
    check("wrap17_main", word_cnt, 17);

    // Asynchronous reset between edges with a full buffer.
    rif.out_ready = 1'b0;
    src_q.push_back(8'hD0);
    src_q.push_back(8'hD1);
    src_q.push_back(8'hD2);
    drive_src();
    repeat (3) tick();
    check("ar_pre_level", buf_level, 2);
    #2;
    rrst_n = 1'b0;
    #1;
    check("ar_valid", rif.out_valid, 0);
    check("ar_rinc", rif.rinc, 0);
    check("ar_level", buf_level, 0);
    check("ar_cnt", word_cnt, 0);
    model_reset();
    @(negedge rclk);
    rrst_n = 1'b1;
    rif.out_ready = 1'b1;
    drive_src();
    tick();
    check("ar_first", rif.out_data, 8'hD2);
    repeat (2) tick();

    // Random stalls, backpressure and occasional flushes.
    for (int i = 0; i < 400; i++) begin
      while (src_q.size() < 4) src_q.push_back(DSIZE'($urandom_range(0, 255)));
      stall = ($urandom_range(0, 3) == 0);
      rif.out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 31) == 0);
      drive_src();
      tick();
    end
    flush = 1'b0;
    stall = 1'b0;
    drive_src();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 The block SHALL have parameter DSIZE, default 8, data word width matching the FIFO data width.
REQ-002 The block SHALL have parameter CSIZE, default 16, width of the delivered-word counter.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset:
  - rclk  input  1  read-domain clock; all state changes on its rising edge.
  - rrst_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have the FIFO read-side ports:
  - rempty  input  1  FIFO empty flag, registered in the rclk domain.
  - rdata  input  DSIZE  FIFO head word, valid whenever rempty=0.
  - rinc  output  1  pop request to the FIFO.
REQ-005 The block SHALL have the downstream stream ports:
  - out_valid  output  1  out_data holds a word.
  - out_ready  input  1  consumer accepts the word this cycle.
  - out_data  output  DSIZE  head word of the skid buffer.
REQ-006 The block SHALL have the control and status ports:
  - flush  input  1  synchronous discard of buffered words.
  - buf_level  output  2  buffer occupancy, 0..2.
  - word_cnt  output  CSIZE  count of accepted words.

Function
REQ-007 The block SHALL contain a 2-entry buffer with a 1-bit write index, a 1-bit read index and a 2-bit count.
REQ-008 rinc SHALL be combinational: rinc = !rempty && (count < 2) && !flush; rinc SHALL NOT depend on out_ready.
REQ-009 When rinc=1 at a rising edge, the block SHALL write rdata into the entry at the write index and toggle the write index.
REQ-010 out_valid SHALL equal (count != 0); out_data SHALL be the entry at the read index, driven directly from registers.
REQ-011 A transfer SHALL occur when out_valid && out_ready at a rising edge; the read index SHALL then toggle and word_cnt SHALL increment.
REQ-012 On a simultaneous push and transfer, count SHALL stay unchanged and both indices SHALL toggle.
REQ-013 Latency: with rempty=0 in cycle N and count<2, the word SHALL appear with out_valid=1 in cycle N+1.
REQ-014 With count=1, rempty=0 and out_ready held at 1, the block SHALL sustain one word per cycle.
REQ-015 At count=2 the block SHALL hold rinc=0 regardless of rempty; no word SHALL be lost or duplicated.
REQ-016 out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-017 When flush=1 at an edge, the block SHALL:
  - set count to 0 and both indices to 0;
  - perform no transfer and leave word_cnt unchanged;
  - hold rinc=0 during that cycle, so no FIFO word is consumed.
REQ-018 word_cnt SHALL wrap from 2^CSIZE-1 to 0 without saturation.
REQ-019 buf_level SHALL equal count.
REQ-020 Words SHALL be delivered in exactly the FIFO pop order.

Reset
REQ-021 While rrst_n=0 the block SHALL asynchronously force count=0, both indices=0, word_cnt=0, out_valid=0, buf_level=0 and rinc=0.
REQ-022 Buffer data registers SHALL NOT be reset; out_data is don't-care while out_valid=0.
REQ-023 Reset asserted mid-transfer SHALL discard all buffered words; the first edge after release SHALL behave as count=0.

Verification
REQ-024 Reset then stream: hold rempty=1; rrst_n rises; after 3 cycles, rempty=0 with rdata=0xA5 and out_ready=1 -> rinc=1 in cycle N, out_valid=1 with out_data=0xA5 in cycle N+1, word_cnt=1.
REQ-025 Backpressure: FIFO supplies 0x01,0x02,0x03 with out_ready=0 -> rinc pops exactly twice, buf_level=2, then rinc=0; raising out_ready delivers 0x01,0x02,0x03 in order on consecutive cycles.
REQ-026 Throughput: 256 words with out_ready=1 and rempty=0 throughout -> one word per cycle after a 1-cycle fill, buf_level=1 steady, word_cnt=256.
REQ-027 Flush: buf_level=2, assert flush for 1 cycle with rempty=0 -> rinc=0 that cycle, buf_level=0 and out_valid=0 next cycle, word_cnt unchanged; the following FIFO word is delivered next.
REQ-028 Wrap: CSIZE=4, accept 17 words -> word_cnt reads 1.
REQ-029 Async reset mid-stream: assert rrst_n=0 between edges with buf_level=2 -> out_valid, rinc and buf_level go 0 immediately, without a clock edge.
